// File: rtl/spike_rate_decoder_pkg.sv
// Shared constants for the spike rate decoder: default widths, saturation limits
// and FSM state encodings.
package spike_dec_pkg;

    localparam int unsigned DEF_CNT_W = 6;
    localparam int unsigned DEF_WIN_W = 8;
    localparam int unsigned DEF_ISI_W = 6;

    localparam int unsigned CNT_MAX = (1 << DEF_CNT_W) - 1;
    localparam int unsigned ISI_MAX = (1 << DEF_ISI_W) - 1;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_COUNT = 1'b1;

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// sat_hit flags an increment that was blocked because the counter was already at its maximum.
module sat_counter #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load_one,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat_hit
);

    logic at_max;

    assign at_max  = (q == {W{1'b1}});
    assign sat_hit = inc & at_max;

    // load_one beats clr, and clr beats inc
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load_one) begin
            q <= W'(1);
        end else if (clr) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a 1-bit spike stream into a per-window spike count and minimum inter-spike interval,
// and presents each result through a valid/ready output register with a sticky overrun flag.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int unsigned CNT_W = $clog2(CNT_MAX + 1),
    parameter int unsigned WIN_W = DEF_WIN_W,
    parameter int unsigned ISI_W = $clog2(ISI_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic             spike_in,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] rate_out,
    output logic [ISI_W-1:0] min_isi_out,
    output logic             sat_out,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy
);

    state_t           state_q;
    logic [WIN_W-1:0] rem_q;
    logic [WIN_W-1:0] win_len_eff;
    logic             counting;
    logic             start;
    logic             last;
    logic             win_clr;

    assign win_len_eff = (window_len == '0) ? WIN_W'(1) : window_len;
    assign counting    = (state_q == ST_COUNT);
    assign start       = !counting && enable;
    assign last        = counting && (rem_q == WIN_W'(1));
    // Counters stay cleared while idle and restart at every window boundary.
    assign win_clr     = !counting || last;
    assign busy        = counting;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else if (start) begin
            state_q <= ST_COUNT;
            rem_q   <= win_len_eff;
        end else if (last) begin
            if (enable) begin
                rem_q <= win_len_eff;
            end else begin
                state_q <= ST_IDLE;
                rem_q   <= '0;
            end
        end else if (counting) begin
            rem_q <= rem_q - WIN_W'(1);
        end
    end

    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat_hit;
    logic [ISI_W-1:0] isi_q;
    logic             unused_isi_sat;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (win_clr),
        .load_one (1'b0),
        .inc      (counting & spike_in),
        .q        (cnt_q),
        .sat_hit  (cnt_sat_hit)
    );

    // A spike on the final cycle must not seed the next window's interval.
    sat_counter #(.W(ISI_W)) u_isi (
        .clk      (clk),
        .reset    (reset),
        .clr      (win_clr),
        .load_one (counting & spike_in & ~last),
        .inc      (counting),
        .q        (isi_q),
        .sat_hit  (unused_isi_sat)
    );

    logic             seen_q;
    logic             sat_q;
    logic [ISI_W-1:0] min_isi_q;
    logic             cnt_bump;
    logic [CNT_W-1:0] fin_rate;
    logic [ISI_W-1:0] fin_min;
    logic             fin_sat;

    // Final values include the current cycle's spike so the last window cycle is counted.
    assign cnt_bump = counting & spike_in & ~cnt_sat_hit;
    assign fin_rate = cnt_q + {{(CNT_W-1){1'b0}}, cnt_bump};
    assign fin_min  = (counting && spike_in && seen_q && (isi_q < min_isi_q)) ? isi_q
                                                                              : min_isi_q;
    assign fin_sat  = sat_q | cnt_sat_hit;

    always_ff @(posedge clk) begin
        if (reset || win_clr) begin
            seen_q    <= 1'b0;
            sat_q     <= 1'b0;
            min_isi_q <= '1;
        end else begin
            seen_q    <= seen_q | spike_in;
            sat_q     <= fin_sat;
            min_isi_q <= fin_min;
        end
    end

    logic load;
    logic drop;

    assign load = last & (~out_valid | out_ready);
    assign drop = last & out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            rate_out    <= '0;
            min_isi_out <= '1;
            sat_out     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load) begin
                out_valid   <= 1'b1;
                rate_out    <= fin_rate;
                min_isi_out <= fin_min;
                sat_out     <= fin_sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: table-driven single windows plus
// hand-written back-to-back, saturation, backpressure and reset sequences.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic       spike_in = 1'b0;
    logic       out_ready = 1'b1;
    logic       clr_overrun = 1'b0;
    logic [5:0] rate_out;
    logic [5:0] min_isi_out;
    logic       sat_out;
    logic       out_valid;
    logic       overrun;
    logic       busy;

    int n_cmp = 0;
    int n_fail = 0;

    spike_rate_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .window_len  (window_len),
        .spike_in    (spike_in),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .rate_out    (rate_out),
        .min_isi_out (min_isi_out),
        .sat_out     (sat_out),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  wl;
        logic [15:0] pat;     // bit i = spike on window cycle i+1
        int          exp_rate;
        int          exp_min;
        int          exp_sat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         n;
        int         any_valid;
        logic [5:0] seq;

        vecs[0] = '{"basic_w8",   8'd8,  16'h0025, 3,  2,  0};
        vecs[1] = '{"w0_spike",   8'd0,  16'h0001, 1,  63, 0};
        vecs[2] = '{"w0_quiet",   8'd0,  16'h0000, 0,  63, 0};
        vecs[3] = '{"w1_spike",   8'd1,  16'h0001, 1,  63, 0};
        vecs[4] = '{"w16_all",    8'd16, 16'hffff, 16, 1,  0};
        vecs[5] = '{"w10_ends",   8'd10, 16'h0201, 2,  9,  0};
        vecs[6] = '{"w12_mixed",  8'd12, 16'h0851, 4,  2,  0};
        vecs[7] = '{"w5_quiet",   8'd5,  16'h0000, 0,  63, 0};
        vecs[8] = '{"w3_adjacent", 8'd3, 16'h0006, 2,  1,  0};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_rate", int'(rate_out), 0);
        check("rst_min_isi", int'(min_isi_out), 63);
        check("rst_sat", int'(sat_out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);

        // Single windows: enable drops right after the start edge, window still completes.
        foreach (vecs[k]) begin
            enable     = 1'b1;
            window_len = vecs[k].wl;
            spike_in   = 1'b1;  // ignored on the start cycle
            tick();
            enable = 1'b0;
            check({vecs[k].name, "_busy_mid"}, int'(busy), 1);
            n = (vecs[k].wl == 8'd0) ? 1 : int'(vecs[k].wl);
            for (int i = 0; i < n; i++) begin
                spike_in = vecs[k].pat[i];
                tick();
            end
            spike_in = 1'b0;
            check({vecs[k].name, "_valid"}, int'(out_valid), 1);
            check({vecs[k].name, "_rate"}, int'(rate_out), vecs[k].exp_rate);
            check({vecs[k].name, "_min_isi"}, int'(min_isi_out), vecs[k].exp_min);
            check({vecs[k].name, "_sat"}, int'(sat_out), vecs[k].exp_sat);
            check({vecs[k].name, "_busy_end"}, int'(busy), 0);
            tick();
            check({vecs[k].name, "_valid_pulse"}, int'(out_valid), 0);
        end

        // Back-to-back 4-cycle windows, spike every cycle.
        enable     = 1'b1;
        window_len = 8'd4;
        tick();
        spike_in = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t % 4 == 0) begin
                check("b2b_valid", int'(out_valid), 1);
                check("b2b_rate", int'(rate_out), 4);
                check("b2b_min_isi", int'(min_isi_out), 1);
                check("b2b_busy", int'(busy), 1);
            end else begin
                check("b2b_gap_valid", int'(out_valid), 0);
            end
        end
        enable   = 1'b0;
        spike_in = 1'b0;
        repeat (4) tick();
        check("b2b_tail_rate", int'(rate_out), 0);
        check("b2b_tail_busy", int'(busy), 0);
        tick();

        // window_len=0 with enable held: every cycle is a window; load coincides with accept.
        seq        = 6'b101101;
        enable     = 1'b1;
        window_len = 8'd0;
        tick();
        for (int i = 0; i < 6; i++) begin
            spike_in = seq[i];
            tick();
            check("w0_run_valid", int'(out_valid), 1);
            check("w0_run_rate", int'(rate_out), int'(seq[i]));
        end
        enable   = 1'b0;
        spike_in = 1'b0;
        tick();
        check("w0_run_last_rate", int'(rate_out), 0);
        check("w0_run_idle", int'(busy), 0);
        tick();
        check("w0_run_drained", int'(out_valid), 0);

        // Saturation then an empty window.
        enable     = 1'b1;
        window_len = 8'd100;
        tick();
        spike_in = 1'b1;
        repeat (100) tick();
        spike_in = 1'b0;
        enable   = 1'b0;
        check("sat_rate", int'(rate_out), 63);
        check("sat_flag", int'(sat_out), 1);
        check("sat_min_isi", int'(min_isi_out), 1);
        repeat (100) tick();
        check("empty_valid", int'(out_valid), 1);
        check("empty_rate", int'(rate_out), 0);
        check("empty_min_isi", int'(min_isi_out), 63);
        check("empty_sat", int'(sat_out), 0);
        tick();

        // Backpressure: second completion is dropped, first result held.
        out_ready  = 1'b0;
        enable     = 1'b1;
        window_len = 8'd5;
        tick();
        spike_in = 1'b1;
        repeat (5) tick();
        check("bp_first_valid", int'(out_valid), 1);
        check("bp_first_rate", int'(rate_out), 5);
        check("bp_first_overrun", int'(overrun), 0);
        enable   = 1'b0;
        spike_in = 1'b0;
        repeat (5) tick();
        check("bp_held_valid", int'(out_valid), 1);
        check("bp_held_rate", int'(rate_out), 5);
        check("bp_held_min_isi", int'(min_isi_out), 1);
        check("bp_overrun_set", int'(overrun), 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("bp_overrun_clr", int'(overrun), 0);
        check("bp_still_valid", int'(out_valid), 1);
        enable = 1'b1;
        tick();
        enable      = 1'b0;
        clr_overrun = 1'b1;
        repeat (5) tick();
        check("bp_set_beats_clr", int'(overrun), 1);
        clr_overrun = 1'b0;
        out_ready   = 1'b1;
        tick();
        check("bp_accept", int'(out_valid), 0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;

        // Reset at cycle 3 of an 8-cycle window.
        enable     = 1'b1;
        window_len = 8'd8;
        tick();
        enable   = 1'b0;
        spike_in = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        spike_in = 1'b0;
        check("rmid_busy", int'(busy), 0);
        check("rmid_valid", int'(out_valid), 0);
        check("rmid_rate", int'(rate_out), 0);
        check("rmid_min_isi", int'(min_isi_out), 63);
        check("rmid_sat", int'(sat_out), 0);
        check("rmid_overrun", int'(overrun), 0);
        any_valid = 0;
        repeat (8) begin
            tick();
            if (out_valid) any_valid = 1;
        end
        check("rmid_no_result", any_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
